// File: rtl/ldmac_host.sv
// Host-side driver for the LDMAC tag engine: buffers a message, loads the IVs while the
// engine is held in reset, serves key/message words on demand and collects the 128-bit tag.
module ldmac_host #(
    parameter int MSG_WORDS = 8,
    parameter int TIMEOUT   = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [63:0]  iv1,
    input  logic [63:0]  iv2,
    input  logic [127:0] exp_tag,
    output logic         busy,
    input  logic [63:0]  msg_data,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic         eng_rst,
    output logic         eng_load_s1,
    output logic         eng_load_s2,
    input  logic         eng_load_k,
    input  logic         eng_load_m,
    output logic [63:0]  eng_din,
    input  logic [63:0]  eng_dout,
    input  logic         eng_dout_valid,
    input  logic         eng_done,
    output logic [127:0] tag,
    output logic         tag_valid,
    output logic         tag_ok,
    output logic         timeout_err,
    output logic [2:0]   dbg_state
);
    // Message stream: a word moves when msg_valid and msg_ready are both high at a rising
    // clk edge; msg_ready is high only while filling, and msg_data must be stable with msg_valid.
    localparam int AW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int MW = $clog2(MSG_WORDS + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW-1:0] LAST_W = AW'(MSG_WORDS - 1);
    localparam logic [MW-1:0] MAX_M  = MW'(MSG_WORDS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_INIT1 = 3'd2,
        S_INIT2 = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t         state, state_next;
    logic [63:0]    msg_buf [MSG_WORDS];
    logic [255:0]   key_r;
    logic [63:0]    iv1_r, iv2_r;
    logic [127:0]   exp_tag_r;
    logic [AW-1:0]  widx;
    logic [MW-1:0]  midx;
    logic [2:0]     kidx;
    logic [TW-1:0]  tcnt;
    logic           got_hi;
    logic           accept;

    assign accept    = msg_ready && msg_valid;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FILL;
            S_FILL:  if (accept && widx == LAST_W) state_next = S_INIT1;
            S_INIT1: state_next = S_INIT2;
            S_INIT2: state_next = S_RUN;
            S_RUN:   if (eng_done || tcnt == T_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_ready   <= 1'b0;
            eng_rst     <= 1'b1;
            eng_load_s1 <= 1'b0;
            eng_load_s2 <= 1'b0;
            busy        <= 1'b0;
        end else begin
            msg_ready   <= (state_next == S_FILL);
            eng_rst     <= (state_next != S_RUN);
            eng_load_s1 <= (state_next == S_INIT1);
            eng_load_s2 <= (state_next == S_INIT2);
            busy        <= (state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FILL && accept) msg_buf[widx] <= msg_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_r       <= '0;
            iv1_r       <= '0;
            iv2_r       <= '0;
            exp_tag_r   <= '0;
            widx        <= '0;
            midx        <= '0;
            kidx        <= '0;
            tcnt        <= '0;
            got_hi      <= 1'b0;
            tag         <= '0;
            tag_valid   <= 1'b0;
            tag_ok      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tag_valid   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    key_r     <= key;
                    iv1_r     <= iv1;
                    iv2_r     <= iv2;
                    exp_tag_r <= exp_tag;
                    widx      <= '0;
                    got_hi    <= 1'b0;
                    tag       <= '0;
                    tag_ok    <= 1'b0;
                end
                S_FILL: if (accept) widx <= widx + 1'b1;
                S_INIT2: begin
                    midx <= '0;
                    kidx <= '0;
                    tcnt <= '0;
                end
                S_RUN: begin
                    tcnt <= tcnt + 1'b1;
                    if (eng_load_k && kidx != 3'd4) kidx <= kidx + 1'b1;
                    if (eng_load_m && midx != MAX_M) midx <= midx + 1'b1;
                    if (eng_dout_valid && !eng_done && !got_hi) begin
                        tag[127:64] <= eng_dout;
                        got_hi      <= 1'b1;
                    end
                    // A done without a prior first half still finishes, leaving the upper half zero.
                    if (eng_done) begin
                        if (eng_dout_valid) tag[63:0] <= eng_dout;
                        tag_valid <= 1'b1;
                        tag_ok    <= ({tag[127:64], eng_dout_valid ? eng_dout : tag[63:0]} == exp_tag_r);
                    end else if (tcnt == T_LAST) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The engine samples eng_din in the same cycle it raises load_k, so this path is combinational.
    always_comb begin
        eng_din = '0;
        case (state)
            S_INIT1: eng_din = iv1_r;
            S_INIT2: eng_din = iv2_r;
            S_RUN: begin
                if (eng_load_k) begin
                    case (kidx)
                        3'd0:    eng_din = key_r[255:192];
                        3'd1:    eng_din = key_r[191:128];
                        3'd2:    eng_din = key_r[127:64];
                        3'd3:    eng_din = key_r[63:0];
                        default: eng_din = '0;
                    endcase
                end else if (midx != MAX_M) begin
                    eng_din = msg_buf[midx[AW-1:0]];
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/ldmac_host.md
Name: ldmac_host

Overview:
- Host-side driver for the LDMAC tag engine. It is the supplier end of the engine's load_s1/load_s2/load_k/load_m/din strobe interface, and the collector end of its dout/dout_valid/done interface.
- Operating sequence:
  - Buffers a complete message from an upstream ready/valid stream.
  - Holds the engine in reset while loading both IV halves.
  - Releases the engine and serves message and key words on demand.
  - Assembles the 128-bit tag and compares it against an expected tag.
- The engine cannot stall, so every word it can request must already be on-chip before the engine is released.

Parameters:
- MSG_WORDS, 8: 64-bit message blocks per tag; must equal the engine's block count.
- TIMEOUT, 512: cycles allowed in RUN before timeout_err.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled in IDLE only
- key  in  256  {k1_hi,k1_lo,k2_hi,k2_lo}; captured on accepted start
- iv1  in  64  initial s1; captured on accepted start
- iv2  in  64  initial s2; captured on accepted start
- exp_tag  in  128  expected tag; captured on accepted start
- busy  out  1  high from accepted start until tag_valid or timeout_err
- msg_data  in  64  message word
- msg_valid  in  1  upstream valid
- msg_ready  out  1  high in FILL only
- eng_rst  out  1  engine reset
- eng_load_s1  out  1  engine s1 load
- eng_load_s2  out  1  engine s2 load
- eng_load_k  in  1  engine key request (combinational in engine)
- eng_load_m  in  1  engine message-advance pulse
- eng_din  out  64  engine data input
- eng_dout  in  64  engine result
- eng_dout_valid  in  1  result valid
- eng_done  in  1  final result
- tag  out  128  collected tag
- tag_valid  out  1  one-cycle pulse
- tag_ok  out  1  tag==exp_tag; valid with tag_valid, held until next start
- timeout_err  out  1  one-cycle pulse

Behaviour:
- Reset:
  - FSM goes to IDLE; counters 0.
  - eng_rst=1 (eng_rst = rst | state in {IDLE,FILL,INIT1,INIT2}).
  - eng_load_s1/s2=0, eng_din=0, msg_ready=0, busy=0.
  - tag=0, tag_valid=0, tag_ok=0, timeout_err=0.
  - Reset mid-job aborts the job; no tag_valid and no timeout_err are produced.
- IDLE:
  - start=1 captures key/iv1/iv2/exp_tag, clears tag_ok and widx, and moves to FILL next cycle.
  - start while not IDLE is ignored.
- FILL:
  - msg_ready=1; each msg_valid&msg_ready writes buf[widx] and increments widx.
  - The cycle the word at widx==MSG_WORDS-1 is accepted, go to INIT1. msg_ready drops the next cycle; no extra word is accepted.
- INIT1 (1 cycle): eng_rst=1, eng_load_s1=1, eng_din=iv1.
- INIT2 (1 cycle): eng_rst=1, eng_load_s2=1, eng_din=iv2. Then enter RUN; midx=0, kidx=0, tcnt=0.
- RUN: eng_rst=0.
  - eng_din is combinational: eng_load_k ? keyword[kidx] : buf[midx]. keyword order: 0=k1_hi, 1=k1_lo, 2=k2_hi, 3=k2_lo.
  - Key: every cycle eng_load_k=1, kidx increments; it saturates at 4, and requests beyond that are served 0.
  - Message: eng_load_m=1 increments midx; it saturates at MSG_WORDS. With midx==MSG_WORDS and no load_k, eng_din=0.
  - Result: first eng_dout_valid loads tag[127:64]. eng_dout_valid with eng_done loads tag[63:0].
  - End of job: the cycle after eng_done, tag_valid=1 and tag_ok=(tag==exp_tag); busy=0; return to IDLE.
  - Order error: eng_done arriving before any first half still completes; tag[127:64] stays 0.
  - Timeout: tcnt increments each RUN cycle. tcnt==TIMEOUT-1 without done gives a timeout_err pulse; go to IDLE and assert eng_rst.
  - Simultaneous done and timeout: done wins.
- Output registers: all outputs except eng_din are registered. eng_din is combinational from state, the counters and eng_load_k.

Test Plan:
- Reset, then start with iv1=0x0123456789ABCDEF, iv2=0xFEDCBA9876543210 and 8 words 0x10..0x17 -> msg_ready high for exactly 8 accepts, then eng_din=iv1 with load_s1, then iv2 with load_s2; eng_rst drops 2 cycles after the last accept.
- Cycle-accurate engine stub:
  - Required eng_din sequence: msg 0x10..0x17 in order, each held until its load_m.
  - Key words k1_hi, k1_lo, k2_hi, k2_lo appear exactly in the 4 load_k cycles.
  - Stub dout 0xAAAA..AA then 0x5555..55 with exp_tag matching -> tag=0xAAAA..AA5555..55, tag_valid 1 cycle, tag_ok=1.
- Same job with exp_tag bit 0 flipped -> tag_valid=1, tag_ok=0.
- msg_valid toggling every other cycle, with 3 extra words offered after the 8th -> only 8 accepted; eng_din order unchanged.
- Stub never asserts done, TIMEOUT=512 -> timeout_err pulse exactly 512 cycles after RUN entry; busy=0; eng_rst=1; no tag_valid.
- rst asserted during RUN at midx=3 -> next cycle IDLE, eng_rst=1, no tag_valid. A following clean job produces the correct tag. start asserted during FILL is ignored.
